// File: rtl/sev_seg_capture.sv
// sev_seg_capture: recovers hex digits from an active-low abcdefg pad bus and delivers them through a one-deep valid/ready buffer.
// Optional macro SEV_SEG_CAPTURE_ERRCNT_EN adds a saturating illegal-glyph counter on err_count.
module sev_seg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_n,
    input  logic       out_ready,
    input  logic       ovf_clr,
    output logic       out_valid,
    output logic [3:0] out_digit,
    output logic       out_err,
`ifdef SEV_SEG_CAPTURE_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    output logic       overflow
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [6:0] BLANK   = 7'h7F;

    typedef enum logic {TRACK, SETTLED} state_t;

    state_t     state_q, state_d;
    logic [6:0] sync1_q, sync1_d;
    logic [6:0] sync_q, sync_d;
    logic [6:0] cand_q, cand_d;
    logic [6:0] last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       out_valid_q, out_valid_d;
    logic [3:0] out_digit_q, out_digit_d;
    logic       out_err_q, out_err_d;
    logic       overflow_q, overflow_d;

    logic [3:0] dec_digit;
    logic       dec_err;
    logic       commit;
    logic       new_pattern;
    logic       emit;
    logic       buf_free;

    always_comb begin
        dec_digit = 4'h0;
        dec_err   = 1'b0;
        case (cand_q)
            7'b0000001: dec_digit = 4'h0;
            7'b1001111: dec_digit = 4'h1;
            7'b0010010: dec_digit = 4'h2;
            7'b0000110: dec_digit = 4'h3;
            7'b1001100: dec_digit = 4'h4;
            7'b0100100: dec_digit = 4'h5;
            7'b0100000: dec_digit = 4'h6;
            7'b0001111: dec_digit = 4'h7;
            7'b0000000: dec_digit = 4'h8;
            7'b0000100: dec_digit = 4'h9;
            7'b0001000: dec_digit = 4'hA;
            7'b1100000: dec_digit = 4'hB;
            7'b0110001: dec_digit = 4'hC;
            7'b1000010: dec_digit = 4'hD;
            7'b0110000: dec_digit = 4'hE;
            7'b0111000: dec_digit = 4'hF;
            default:    dec_err   = 1'b1;
        endcase
    end

    // Stability tracker: a pattern must survive STABLE_CYCLES clocks in cand before it commits.
    always_comb begin
        sync1_d = seg_n;
        sync_d  = sync1_q;
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            TRACK: begin
                if (sync_q != cand_q) begin
                    cand_d = sync_q;
                    cnt_d  = 8'd0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    commit  = 1'b1;
                    state_d = SETTLED;
                end
            end
            SETTLED: begin
                if (sync_q != cand_q) begin
                    cand_d  = sync_q;
                    cnt_d   = 8'd0;
                    state_d = TRACK;
                end
            end
            default: state_d = TRACK;
        endcase
    end

    // Blank updates last without emitting, so a digit repeated across a blank is reported again.
    always_comb begin
        new_pattern = commit && (cand_q != last_q);
        emit        = new_pattern && (cand_q != BLANK);
        buf_free    = !out_valid_q || out_ready;
        last_d      = new_pattern ? cand_q : last_q;
        out_valid_d = out_valid_q;
        out_digit_d = out_digit_q;
        out_err_d   = out_err_q;
        overflow_d  = ovf_clr ? 1'b0 : overflow_q;
        if (emit && buf_free) begin
            out_valid_d = 1'b1;
            out_digit_d = dec_digit;
            out_err_d   = dec_err;
        end else if (emit) begin
            overflow_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TRACK;
            sync1_q     <= BLANK;
            sync_q      <= BLANK;
            cand_q      <= BLANK;
            last_q      <= BLANK;
            cnt_q       <= 8'd0;
            out_valid_q <= 1'b0;
            out_digit_q <= 4'h0;
            out_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync_q      <= sync_d;
            cand_q      <= cand_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_digit_q <= out_digit_d;
            out_err_q   <= out_err_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef SEV_SEG_CAPTURE_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Dropped commits count too; an increment in the clearing cycle still lands.
    always_comb begin
        err_count_d = ovf_clr ? 8'd0 : err_count_q;
        if (emit && dec_err && (err_count_d != 8'hFF)) begin
            err_count_d = err_count_d + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

    assign out_valid = out_valid_q;
    assign out_digit = out_digit_q;
    assign out_err   = out_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sev_seg_capture.sv
// Self-checking bench for sev_seg_capture: glyph table vectors plus hand-written timing, backpressure and reset sequences.
// Emitted digits are compared against a scoreboard queue whenever the DUT hands a digit over.
module tb_sev_seg_capture;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_n;
    logic       out_ready;
    logic       ovf_clr;
    logic       out_valid;
    logic [3:0] out_digit;
    logic       out_err;
    logic       overflow;
`ifdef SEV_SEG_CAPTURE_ERRCNT_EN
    logic [7:0] err_count;
`endif

    typedef struct {
        logic [6:0] seg;
        int         hold;
        logic       emit;
        logic [3:0] digit;
        logic       err;
    } vec_t;

    typedef struct {
        logic [3:0] digit;
        logic       err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checkCount = 0;
    int   errorCount = 0;

    sev_seg_capture #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_n     (seg_n),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .out_digit (out_digit),
        .out_err   (out_err),
`ifdef SEV_SEG_CAPTURE_ERRCNT_EN
        .err_count (err_count),
`endif
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] seg, input int cycles);
        seg_n = seg;
        waitEdges(cycles);
    endtask

    task automatic pushExp(input logic [3:0] d, input logic e);
        exp_t x;
        x.digit = d;
        x.err   = e;
        sb.push_back(x);
    endtask

    // Every handshake must match the oldest expected digit.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpected_emit: got digit %0h err %0b, required no emit", out_digit, out_err);
            end else begin
                exp_t x;
                x = sb.pop_front();
                checkOutput("sb_digit", 32'(out_digit), 32'(x.digit));
                checkOutput("sb_err", 32'(out_err), 32'(x.err));
            end
        end
    end

    initial begin
        vecs.push_back('{7'b0010010, 2,  1'b0, 4'h0, 1'b0});
        vecs.push_back('{7'b0100100, 10, 1'b1, 4'h5, 1'b0});
        vecs.push_back('{7'b1010101, 10, 1'b1, 4'h0, 1'b1});
        vecs.push_back('{7'b0001000, 10, 1'b1, 4'hA, 1'b0});
        vecs.push_back('{7'b1100000, 10, 1'b1, 4'hB, 1'b0});
        vecs.push_back('{7'b0110001, 10, 1'b1, 4'hC, 1'b0});
        vecs.push_back('{7'b1000010, 10, 1'b1, 4'hD, 1'b0});
        vecs.push_back('{7'b0110000, 10, 1'b1, 4'hE, 1'b0});
        vecs.push_back('{7'b0111000, 10, 1'b1, 4'hF, 1'b0});
        vecs.push_back('{7'b0000001, 10, 1'b1, 4'h0, 1'b0});
        vecs.push_back('{7'b0010010, 10, 1'b1, 4'h2, 1'b0});
        vecs.push_back('{7'b0000110, 10, 1'b1, 4'h3, 1'b0});
        vecs.push_back('{7'b1001100, 10, 1'b1, 4'h4, 1'b0});
        vecs.push_back('{7'b0100000, 10, 1'b1, 4'h6, 1'b0});
        vecs.push_back('{7'b0001111, 10, 1'b1, 4'h7, 1'b0});
        vecs.push_back('{7'b0000100, 10, 1'b1, 4'h9, 1'b0});

        rst_n     = 1'b0;
        seg_n     = 7'b0000000;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        waitEdges(2);
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_digit", 32'(out_digit), 0);
        checkOutput("rst_err", 32'(out_err), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
`ifdef SEV_SEG_CAPTURE_ERRCNT_EN
        checkOutput("rst_err_count", 32'(err_count), 0);
`endif

        // Release with 8 already on the bus: first digit appears on the seventh edge.
        rst_n = 1'b1;
        waitEdges(6);
        checkOutput("first_valid_early", 32'(out_valid), 0);
        waitEdges(1);
        checkOutput("first_valid", 32'(out_valid), 1);
        checkOutput("first_digit", 32'(out_digit), 8);
        pushExp(4'h8, 1'b0);
        out_ready = 1'b1;
        waitEdges(1);
        checkOutput("first_accepted", 32'(out_valid), 0);

        // Basic: a single-cycle pulse seven edges after apply, nothing more while held.
        pushExp(4'h1, 1'b0);
        applyStimulus(7'b1001111, 6);
        checkOutput("basic_valid_early", 32'(out_valid), 0);
        waitEdges(1);
        checkOutput("basic_valid", 32'(out_valid), 1);
        checkOutput("basic_digit", 32'(out_digit), 1);
        checkOutput("basic_err", 32'(out_err), 0);
        waitEdges(1);
        checkOutput("basic_pulse_end", 32'(out_valid), 0);
        waitEdges(3);
        checkOutput("basic_no_repeat", 32'(out_valid), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].emit) pushExp(vecs[i].digit, vecs[i].err);
            applyStimulus(vecs[i].seg, vecs[i].hold);
            checkOutput("vec_idle", 32'(out_valid), 0);
        end
        checkOutput("vec_sb_drained", 32'(sb.size()), 0);
`ifdef SEV_SEG_CAPTURE_ERRCNT_EN
        checkOutput("vec_err_count", 32'(err_count), 1);
`endif

        // Backpressure: the second commit is dropped and flagged.
        out_ready = 1'b0;
        pushExp(4'h2, 1'b0);
        applyStimulus(7'b0010010, 10);
        checkOutput("bp_valid", 32'(out_valid), 1);
        checkOutput("bp_digit", 32'(out_digit), 2);
        applyStimulus(7'b0100100, 10);
        checkOutput("bp_hold_digit", 32'(out_digit), 2);
        checkOutput("bp_hold_valid", 32'(out_valid), 1);
        checkOutput("bp_overflow", 32'(overflow), 1);
        out_ready = 1'b1;
        waitEdges(1);
        checkOutput("bp_accepted", 32'(out_valid), 0);
        checkOutput("bp_overflow_sticky", 32'(overflow), 1);
        ovf_clr = 1'b1;
        waitEdges(1);
        ovf_clr = 1'b0;
        checkOutput("bp_overflow_clr", 32'(overflow), 0);
`ifdef SEV_SEG_CAPTURE_ERRCNT_EN
        checkOutput("bp_err_count_clr", 32'(err_count), 0);
`endif

        // Repeat across a blank re-emits.
        pushExp(4'h8, 1'b0);
        applyStimulus(7'b0000000, 10);
        applyStimulus(7'b1111111, 10);
        checkOutput("blank_no_emit", 32'(sb.size()), 0);
        pushExp(4'h8, 1'b0);
        applyStimulus(7'b0000000, 10);
        checkOutput("blank_sb_drained", 32'(sb.size()), 0);

        // Asynchronous reset discards a buffered digit and the last-seen pattern.
        out_ready = 1'b0;
        applyStimulus(7'b0000110, 10);
        checkOutput("rr_valid", 32'(out_valid), 1);
        checkOutput("rr_digit", 32'(out_digit), 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rr_async_valid", 32'(out_valid), 0);
        checkOutput("rr_async_digit", 32'(out_digit), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pushExp(4'h3, 1'b0);
        out_ready = 1'b1;
        waitEdges(6);
        checkOutput("rr_reemit_early", 32'(out_valid), 0);
        waitEdges(1);
        checkOutput("rr_reemit_valid", 32'(out_valid), 1);
        waitEdges(2);
        checkOutput("final_sb_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
